// File: rtl/mips_cpu_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: opcodes, functs,
// ALU op codes, write-back selects, FSM states and decoded instruction classes.
package mips_cpu_pkg;

  localparam logic [5:0] OP_RTYPE  = 6'd0;
  localparam logic [5:0] OP_REGIMM = 6'd1;
  localparam logic [5:0] OP_J      = 6'd2;
  localparam logic [5:0] OP_JAL    = 6'd3;
  localparam logic [5:0] OP_BEQ    = 6'd4;
  localparam logic [5:0] OP_BNE    = 6'd5;
  localparam logic [5:0] OP_BLEZ   = 6'd6;
  localparam logic [5:0] OP_BGTZ   = 6'd7;
  localparam logic [5:0] OP_ADDIU  = 6'd9;
  localparam logic [5:0] OP_SLTI   = 6'd10;
  localparam logic [5:0] OP_SLTIU  = 6'd11;
  localparam logic [5:0] OP_ANDI   = 6'd12;
  localparam logic [5:0] OP_ORI    = 6'd13;
  localparam logic [5:0] OP_XORI   = 6'd14;
  localparam logic [5:0] OP_LUI    = 6'd15;
  localparam logic [5:0] OP_LB     = 6'd32;
  localparam logic [5:0] OP_LH     = 6'd33;
  localparam logic [5:0] OP_LWL    = 6'd34;
  localparam logic [5:0] OP_LW     = 6'd35;
  localparam logic [5:0] OP_LBU    = 6'd36;
  localparam logic [5:0] OP_LHU    = 6'd37;
  localparam logic [5:0] OP_LWR    = 6'd38;
  localparam logic [5:0] OP_SB     = 6'd40;
  localparam logic [5:0] OP_SH     = 6'd41;
  localparam logic [5:0] OP_SW     = 6'd43;

  localparam logic [5:0] FN_JR    = 6'd8;
  localparam logic [5:0] FN_JALR  = 6'd9;
  localparam logic [5:0] FN_MFHI  = 6'd16;
  localparam logic [5:0] FN_MFLO  = 6'd18;
  localparam logic [5:0] FN_MULT  = 6'd24;
  localparam logic [5:0] FN_MULTU = 6'd25;
  localparam logic [5:0] FN_DIV   = 6'd26;
  localparam logic [5:0] FN_DIVU  = 6'd27;

  typedef enum logic [3:0] {
    ALU_RTYPE = 4'd0,
    ALU_LTZ   = 4'd1,
    ALU_GEZ   = 4'd2,
    ALU_EQ    = 4'd3,
    ALU_NE    = 4'd4,
    ALU_LEZ   = 4'd5,
    ALU_GTZ   = 4'd6,
    ALU_ADD   = 4'd7,
    ALU_SLT   = 4'd8,
    ALU_SLTU  = 4'd9,
    ALU_AND   = 4'd10,
    ALU_OR    = 4'd11,
    ALU_XOR   = 4'd12,
    ALU_LUI   = 4'd13
  } aluop_t;

  localparam logic [1:0] REGDST_RT  = 2'b00;
  localparam logic [1:0] REGDST_RD  = 2'b01;
  localparam logic [1:0] REGDST_R31 = 2'b10;

  localparam logic [1:0] MTR_ALU = 2'b00;
  localparam logic [1:0] MTR_MEM = 2'b01;
  localparam logic [1:0] MTR_PC4 = 2'b10;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_MULDIV_WAIT,
    S_HALT
  } state_t;

  typedef enum logic [3:0] {
    C_ALU,
    C_LOAD,
    C_STORE,
    C_BRANCH,
    C_BRANCH_LINK,
    C_J,
    C_JAL,
    C_JR,
    C_JALR,
    C_MULDIV,
    C_MFHILO,
    C_ILLEGAL
  } iclass_t;

endpackage

// File: rtl/mips_cpu_decode.sv
// Combinational instruction classifier: IR fields to class, ALU op and
// datapath selects. Anything not listed decodes as C_ILLEGAL.
module mips_cpu_decode
  import mips_cpu_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic [4:0] rt,
  output logic [3:0] cls,
  output logic [3:0] aluop,
  output logic       alusrc,
  output logic [1:0] regdst,
  output logic [1:0] memtoreg
);

  iclass_t c;
  aluop_t  op;
  logic    unused_rt;

  // Only rt[4] (link) and rt[0] (GEZ vs LTZ) matter for REGIMM.
  assign unused_rt = ^rt[3:1];

  always_comb begin
    c        = C_ILLEGAL;
    op       = ALU_RTYPE;
    alusrc   = 1'b0;
    regdst   = REGDST_RT;
    memtoreg = MTR_ALU;
    case (opcode)
      OP_RTYPE: begin
        regdst = REGDST_RD;
        case (funct)
          FN_JR:   c = C_JR;
          FN_JALR: begin
            c        = C_JALR;
            memtoreg = MTR_PC4;
          end
          FN_MFHI, FN_MFLO:                    c = C_MFHILO;
          FN_MULT, FN_MULTU, FN_DIV, FN_DIVU:  c = C_MULDIV;
          default:                             c = C_ALU;
        endcase
      end
      OP_REGIMM: begin
        op = rt[0] ? ALU_GEZ : ALU_LTZ;
        if (rt[4]) begin
          c        = C_BRANCH_LINK;
          regdst   = REGDST_R31;
          memtoreg = MTR_PC4;
        end else begin
          c = C_BRANCH;
        end
      end
      OP_J: begin
        c  = C_J;
        op = ALU_ADD;
      end
      OP_JAL: begin
        c        = C_JAL;
        op       = ALU_ADD;
        regdst   = REGDST_R31;
        memtoreg = MTR_PC4;
      end
      OP_BEQ:  begin c = C_BRANCH; op = ALU_EQ;  end
      OP_BNE:  begin c = C_BRANCH; op = ALU_NE;  end
      OP_BLEZ: begin c = C_BRANCH; op = ALU_LEZ; end
      OP_BGTZ: begin c = C_BRANCH; op = ALU_GTZ; end
      OP_ADDIU: begin c = C_ALU; alusrc = 1'b1; op = ALU_ADD;  end
      OP_SLTI:  begin c = C_ALU; alusrc = 1'b1; op = ALU_SLT;  end
      OP_SLTIU: begin c = C_ALU; alusrc = 1'b1; op = ALU_SLTU; end
      OP_ANDI:  begin c = C_ALU; alusrc = 1'b1; op = ALU_AND;  end
      OP_ORI:   begin c = C_ALU; alusrc = 1'b1; op = ALU_OR;   end
      OP_XORI:  begin c = C_ALU; alusrc = 1'b1; op = ALU_XOR;  end
      OP_LUI:   begin c = C_ALU; alusrc = 1'b1; op = ALU_LUI;  end
      OP_LB, OP_LH, OP_LWL, OP_LW, OP_LBU, OP_LHU, OP_LWR: begin
        c        = C_LOAD;
        op       = ALU_ADD;
        alusrc   = 1'b1;
        memtoreg = MTR_MEM;
      end
      OP_SB, OP_SH, OP_SW: begin
        c      = C_STORE;
        op     = ALU_ADD;
        alusrc = 1'b1;
      end
      default: ;
    endcase
  end

  assign cls   = c;
  assign aluop = op;

endmodule

// File: rtl/mips_cpu_control_multicycle.sv
// Multi-cycle MIPS control FSM with bus wait handling and halt-on-PC-zero.
// Define MULDIV_STALL_EN to stall on the mult/div unit via muldiv_busy.
module mips_cpu_control_multicycle
  import mips_cpu_pkg::*;
#(
  parameter int ALUOP_W      = 4,
  parameter int MEM_WAIT_MAX = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic [4:0]         rt,
  input  logic               waitrequest,
  input  logic               muldiv_busy,
  input  logic               pc_zero,
  output logic               active,
  output logic               mem_read,
  output logic               mem_write,
  output logic               iord,
  output logic               ir_write,
  output logic               pc_write,
  output logic [1:0]         regdst,
  output logic [1:0]         memtoreg,
  output logic [ALUOP_W-1:0] aluop,
  output logic               alusrc,
  output logic               regwrite,
  output logic               branch,
  output logic               jump,
  output logic               muldiv_start,
  output logic               illegal_instr,
  output logic               bus_error
);

  localparam int CNT_W = (MEM_WAIT_MAX > 0) ? $clog2(MEM_WAIT_MAX + 1) : 1;

  state_t           state, next;
  logic [CNT_W-1:0] wait_cnt;
  logic [3:0]       cls_raw, dec_aluop;
  iclass_t          cls;
  logic             dec_alusrc;
  logic [1:0]       dec_regdst, dec_memtoreg;
  logic             bus_wait, timeout, muldiv_hold, stall_exec;

  mips_cpu_decode u_decode (
    .opcode   (opcode),
    .funct    (funct),
    .rt       (rt),
    .cls      (cls_raw),
    .aluop    (dec_aluop),
    .alusrc   (dec_alusrc),
    .regdst   (dec_regdst),
    .memtoreg (dec_memtoreg)
  );

  assign cls = iclass_t'(cls_raw);

`ifdef MULDIV_STALL_EN
  localparam state_t S_MULDIV_NEXT = S_MULDIV_WAIT;
  assign muldiv_hold = muldiv_busy;
`else
  localparam state_t S_MULDIV_NEXT = S_FETCH;
  logic unused_busy;
  assign unused_busy = muldiv_busy;
  assign muldiv_hold = 1'b0;
`endif

  assign stall_exec = muldiv_hold && (cls == C_MFHILO);

  // The wait counter only sees bus states; the timeout fires on the cycle
  // that would make the count reach MEM_WAIT_MAX.
  assign bus_wait = ((state == S_FETCH) || (state == S_MEM)) && waitrequest;
  assign timeout  = (MEM_WAIT_MAX > 0) && bus_wait &&
                    (wait_cnt == CNT_W'(MEM_WAIT_MAX - 1));

  assign active = reset || (state != S_HALT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_FETCH;
      wait_cnt  <= '0;
      bus_error <= 1'b0;
    end else begin
      state <= next;
      if (timeout)
        bus_error <= 1'b1;
      if (!bus_wait)
        wait_cnt <= '0;
      else if (wait_cnt != '1)
        wait_cnt <= wait_cnt + 1'b1;
    end
  end

  always_comb begin
    next          = state;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    iord          = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    regwrite      = 1'b0;
    branch        = 1'b0;
    jump          = 1'b0;
    muldiv_start  = 1'b0;
    illegal_instr = 1'b0;
    aluop         = '0;
    alusrc        = 1'b0;
    regdst        = REGDST_RT;
    memtoreg      = MTR_ALU;

    // Datapath selects track the latched IR for the life of the instruction.
    if ((state != S_FETCH) && (state != S_HALT)) begin
      aluop    = ALUOP_W'(dec_aluop);
      alusrc   = dec_alusrc;
      regdst   = dec_regdst;
      memtoreg = dec_memtoreg;
    end

    case (state)
      S_FETCH: begin
        mem_read = 1'b1;
        ir_write = !waitrequest;
        pc_write = !waitrequest;
        if (timeout)
          next = S_HALT;
        else if (!waitrequest)
          next = S_DECODE;
      end
      S_DECODE: begin
        illegal_instr = (cls == C_ILLEGAL);
        next          = (cls == C_ILLEGAL) ? S_FETCH : S_EXEC;
      end
      S_EXEC: begin
        branch       = (cls == C_BRANCH) || (cls == C_BRANCH_LINK);
        jump         = (cls == C_J) || (cls == C_JAL) || (cls == C_JR) || (cls == C_JALR);
        muldiv_start = (cls == C_MULDIV);
        if (!stall_exec) begin
          case (cls)
            C_ALU, C_MFHILO, C_JAL, C_JALR, C_BRANCH_LINK: next = S_WB;
            C_LOAD, C_STORE:                               next = S_MEM;
            C_MULDIV:                                      next = S_MULDIV_NEXT;
            default:                                       next = S_FETCH;
          endcase
        end
      end
      S_MEM: begin
        iord      = 1'b1;
        mem_read  = (cls == C_LOAD);
        mem_write = (cls == C_STORE);
        if (timeout)
          next = S_HALT;
        else if (!waitrequest)
          next = (cls == C_LOAD) ? S_WB : S_FETCH;
      end
      S_WB: begin
        regwrite = 1'b1;
        next     = S_FETCH;
      end
      S_MULDIV_WAIT: begin
        if (!muldiv_hold)
          next = S_FETCH;
      end
      S_HALT:  next = S_HALT;
      default: next = S_FETCH;
    endcase

    // Returning to PC 0 means the program has finished.
    if ((next == S_FETCH) && (state != S_FETCH) && pc_zero)
      next = S_HALT;

    if (reset) begin
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      iord          = 1'b0;
      ir_write      = 1'b0;
      pc_write      = 1'b0;
      regwrite      = 1'b0;
      branch        = 1'b0;
      jump          = 1'b0;
      muldiv_start  = 1'b0;
      illegal_instr = 1'b0;
      aluop         = '0;
      alusrc        = 1'b0;
      regdst        = REGDST_RT;
      memtoreg      = MTR_ALU;
    end
  end

endmodule

// File: tb/tb_mips_cpu_control_multicycle.sv
module tb_mips_cpu_control_multicycle;

  localparam int MAXW = 4;
`ifdef MULDIV_STALL_EN
  localparam bit STALL = 1'b1;
`else
  localparam bit STALL = 1'b0;
`endif

  localparam int K_ALU = 0, K_LD = 1, K_ST = 2, K_BR = 3, K_BRL = 4, K_J = 5,
                 K_JAL = 6, K_JR = 7, K_JALR = 8, K_MD = 9, K_MF = 10, K_ILL = 11;

  logic       clk = 1'b0, reset = 1'b1;
  logic [5:0] opcode = '0, funct = '0;
  logic [4:0] rt = '0;
  logic       waitrequest = 1'b0, muldiv_busy = 1'b0, pc_zero = 1'b0;
  logic       active, mem_read, mem_write, iord, ir_write, pc_write;
  logic [1:0] regdst, memtoreg;
  logic [3:0] aluop;
  logic       alusrc, regwrite, branch, jump, muldiv_start, illegal_instr, bus_error;

  mips_cpu_control_multicycle #(.ALUOP_W(4), .MEM_WAIT_MAX(MAXW)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .rt(rt),
    .waitrequest(waitrequest), .muldiv_busy(muldiv_busy), .pc_zero(pc_zero),
    .active(active), .mem_read(mem_read), .mem_write(mem_write), .iord(iord),
    .ir_write(ir_write), .pc_write(pc_write), .regdst(regdst), .memtoreg(memtoreg),
    .aluop(aluop), .alusrc(alusrc), .regwrite(regwrite), .branch(branch),
    .jump(jump), .muldiv_start(muldiv_start), .illegal_instr(illegal_instr),
    .bus_error(bus_error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       active, mem_read, mem_write, iord, ir_write, pc_write;
    logic [1:0] regdst, memtoreg;
    logic [3:0] aluop;
    logic       alusrc, regwrite, branch, jump, muldiv_start, illegal_instr, bus_error;
  } outs_t;

  typedef struct {
    logic [47:0] tag;
    bit          rst, wr, busy, pz;
    logic [5:0]  op, fn;
    logic [4:0]  rt;
    outs_t       e, m;
  } rec_t;

  rec_t       plan[$];
  rec_t       sb[$];
  int         checks = 0, errors = 0;
  bit         berr = 1'b0;
  logic [5:0] cur_op = '0, cur_fn = '0;
  logic [4:0] cur_rt = '0;
  outs_t      act;
  int         op_tbl[13] = '{0, 0, 0, 1, 2, 3, 4, 9, 15, 35, 43, 32, 40};
  int         fn_tbl[8]  = '{8, 9, 16, 18, 24, 25, 26, 27};

  assign act = {active, mem_read, mem_write, iord, ir_write, pc_write, regdst, memtoreg,
                aluop, alusrc, regwrite, branch, jump, muldiv_start, illegal_instr, bus_error};

  function automatic outs_t base();
    outs_t o = '0;
    o.active    = 1'b1;
    o.bus_error = berr;
    return o;
  endfunction

  function automatic outs_t smask();
    outs_t o = '1;
    o.aluop = '0; o.alusrc = 1'b0; o.regdst = '0; o.memtoreg = '0;
    return o;
  endfunction

  task automatic classify(input logic [5:0] op, fn, input logic [4:0] r, output int k,
                          output logic [3:0] al, output logic src, output logic [1:0] rd, mt);
    k = K_ILL; al = 4'd0; src = 1'b0; rd = 2'd0; mt = 2'd0;
    if (op == 6'd0) begin
      rd = 2'd1;
      if (fn == 6'd8) k = K_JR;
      else if (fn == 6'd9) begin k = K_JALR; mt = 2'd2; end
      else if (fn inside {6'd16, 6'd18}) k = K_MF;
      else if (fn inside {[6'd24:6'd27]}) k = K_MD;
      else k = K_ALU;
    end else if (op == 6'd1) begin
      k  = r[4] ? K_BRL : K_BR;
      al = r[0] ? 4'd2 : 4'd1;
      if (r[4]) begin rd = 2'd2; mt = 2'd2; end
    end else if (op == 6'd2) k = K_J;
    else if (op == 6'd3) begin k = K_JAL; rd = 2'd2; mt = 2'd2; end
    else if (op inside {[6'd4:6'd7]}) begin k = K_BR; al = 4'(op - 6'd1); end
    else if (op inside {[6'd9:6'd15]}) begin k = K_ALU; src = 1'b1; al = 4'(op - 6'd2); end
    else if (op inside {[6'd32:6'd38]}) begin k = K_LD; al = 4'd7; src = 1'b1; mt = 2'd1; end
    else if (op inside {6'd40, 6'd41, 6'd43}) begin k = K_ST; al = 4'd7; src = 1'b1; end
  endtask

  task automatic add(input logic [47:0] tag, input bit rst, wr, busy, input outs_t e, m);
    rec_t r;
    r.tag = tag; r.rst = rst; r.wr = wr; r.busy = busy; r.pz = 1'($urandom_range(0, 1));
    r.op = cur_op; r.fn = cur_fn; r.rt = cur_rt; r.e = e; r.m = m;
    plan.push_back(r);
  endtask

  task automatic reset_seq();
    outs_t m = smask();
    m.active = 1'b0; m.bus_error = 1'b0;
    add("reset", 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), base(), m);
    berr = 1'b0;
    add("reset", 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), base(), smask());
  endtask

  task automatic halt_seq(input int n);
    outs_t e;
    for (int i = 0; i < n; i++) begin
      e = '0; e.bus_error = berr;
      add("halt", 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), e, smask());
    end
  endtask

  task automatic end_instr(input bit halt);
    rec_t t = plan.pop_back();
    t.pz = halt;
    plan.push_back(t);
    if (halt) begin
      halt_seq(12);
      reset_seq();
    end
  endtask

  task automatic build(input logic [5:0] op, fn, input logic [4:0] r,
                       input int fw, mw, bz, input bit halt);
    int k; logic [3:0] al; logic src; logic [1:0] rd, mt;
    outs_t e, m;
    cur_op = op; cur_fn = fn; cur_rt = r;
    classify(op, fn, r, k, al, src, rd, mt);
    for (int i = 0; i < fw && i < MAXW; i++) begin
      e = base(); e.mem_read = 1'b1;
      add("fetchw", 1'b0, 1'b1, 1'($urandom_range(0, 1)), e, smask());
    end
    if (fw >= MAXW) begin
      berr = 1'b1; halt_seq(8); reset_seq(); return;
    end
    e = base(); e.mem_read = 1'b1; e.ir_write = 1'b1; e.pc_write = 1'b1;
    add("fetch", 1'b0, 1'b0, 1'($urandom_range(0, 1)), e, smask());
    e = base(); e.illegal_instr = (k == K_ILL);
    add("decode", 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), e, smask());
    if (k == K_ILL) begin end_instr(halt); return; end
    if (STALL && k == K_MF)
      for (int i = 0; i < bz; i++) add("exechd", 1'b0, 1'($urandom_range(0, 1)), 1'b1, base(), smask());
    e = base(); m = smask();
    e.branch = (k == K_BR || k == K_BRL);
    e.jump = (k inside {K_J, K_JAL, K_JR, K_JALR});
    e.muldiv_start = (k == K_MD);
    if (k inside {K_ALU, K_LD, K_ST, K_BR, K_BRL}) begin
      e.aluop = al; e.alusrc = src; m.aluop = '1; m.alusrc = 1'b1;
    end
    add("exec", 1'b0, 1'($urandom_range(0, 1)),
        (STALL && k == K_MF) ? 1'b0 : 1'($urandom_range(0, 1)), e, m);
    if (k inside {K_J, K_JR, K_BR} || (k == K_MD && !STALL)) begin end_instr(halt); return; end
    if (k == K_MD) begin
      for (int i = 0; i < bz; i++) add("mdwait", 1'b0, 1'($urandom_range(0, 1)), 1'b1, base(), smask());
      add("mdwait", 1'b0, 1'($urandom_range(0, 1)), 1'b0, base(), smask());
      end_instr(halt); return;
    end
    if (k == K_LD || k == K_ST) begin
      e = base(); m = smask();
      e.iord = 1'b1; e.mem_read = (k == K_LD); e.mem_write = (k == K_ST);
      e.aluop = 4'd7; e.alusrc = 1'b1; m.aluop = '1; m.alusrc = 1'b1;
      for (int i = 0; i < mw && i < MAXW; i++) add("memw", 1'b0, 1'b1, 1'($urandom_range(0, 1)), e, m);
      if (mw >= MAXW) begin
        berr = 1'b1; halt_seq(8); reset_seq(); return;
      end
      add("mem", 1'b0, 1'b0, 1'($urandom_range(0, 1)), e, m);
      if (k == K_ST) begin end_instr(halt); return; end
    end
    e = base(); m = smask();
    e.regwrite = 1'b1; e.regdst = rd; e.memtoreg = mt; m.regdst = '1; m.memtoreg = '1;
    if (k == K_ALU) begin e.aluop = al; e.alusrc = src; m.aluop = '1; m.alusrc = 1'b1; end
    add("wb", 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), e, m);
    end_instr(halt);
  endtask

  task automatic drive();
    rec_t r;
    while (plan.size() != 0) begin
      r = plan.pop_front();
      @(posedge clk); #1;
      reset = r.rst; waitrequest = r.wr; muldiv_busy = r.busy; pc_zero = r.pz;
      opcode = r.op; funct = r.fn; rt = r.rt;
      sb.push_back(r);
    end
  endtask

  always @(negedge clk) begin : monitor
    rec_t r;
    if (sb.size() != 0) begin
      r = sb.pop_front();
      checks++;
      if (((act ^ r.e) & r.m) !== '0) begin
        errors++;
        $display("FAIL %s op=%0d fn=%0d actual=%h expected=%h mask=%h",
                 r.tag, r.op, r.fn, act, r.e, r.m);
      end
    end
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    int fw, mw;
    reset_seq(); drive();
    build(6'd9, 6'd0, 5'd0, 0, 0, 0, 1'b0);  drive();
    build(6'd35, 6'd0, 5'd0, 0, 3, 0, 1'b0); drive();
    build(6'd3, 6'd0, 5'd0, 0, 0, 0, 1'b1);  drive();
    build(6'd0, 6'd32, 5'd0, 6, 0, 0, 1'b0); drive();
    build(6'd0, 6'd26, 5'd0, 0, 0, 6, 1'b0); drive();
    build(6'd63, 6'd0, 5'd0, 0, 0, 0, 1'b0); drive();
    build(6'd1, 6'd0, 5'd17, 1, 0, 0, 1'b0); drive();
    cur_op = 6'd43;
    for (int i = 0; i < 2; i++) begin : midfetch
      outs_t e;
      e = base(); e.mem_read = 1'b1;
      add("fetchw", 1'b0, 1'b1, 1'b0, e, smask());
    end
    reset_seq();
    build(6'd43, 6'd0, 5'd0, 3, 3, 0, 1'b0); drive();
    repeat (300) begin
      logic [5:0] op, fn;
      op = ($urandom_range(0, 1) != 0) ? 6'(op_tbl[$urandom_range(0, 12)]) : 6'($urandom_range(0, 63));
      fn = ($urandom_range(0, 1) != 0) ? 6'(fn_tbl[$urandom_range(0, 7)]) : 6'($urandom_range(0, 63));
      fw = ($urandom_range(0, 24) == 0) ? MAXW : $urandom_range(0, 3);
      mw = ($urandom_range(0, 24) == 0) ? MAXW : $urandom_range(0, 3);
      build(op, fn, 5'($urandom_range(0, 31)), fw, mw, $urandom_range(0, 4),
            ($urandom_range(0, 14) == 0));
      drive();
    end
    repeat (3) @(posedge clk);
    if (checks < 12) begin
      errors++;
      $display("FAIL too few checks: %0d", checks);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    if (errors != 0)
      $display("FAIL %0d mismatches", errors);
    else
      $display("PASS");
    $finish;
  end

endmodule

// File: doc/mips_cpu_control_multicycle.md
# mips_cpu_control_multicycle

Multi-cycle control unit for the bus-interface MIPS CPU, replacing the single-cycle combinational Harvard decoder. It sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states, stalls on the memory `waitrequest` handshake, and optionally stalls on the multiply/divide unit. It halts the core when the program counter returns to address 0. It sits between the instruction register and the datapath muxes, register file, ALU and memory bus.

## Interface
- `ALUOP_W`, default 4: width of `aluop`. Must be at least 4.
- `MEM_WAIT_MAX`, default 0: maximum consecutive `waitrequest` cycles per access. 0 means unbounded.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `opcode`  in  6  IR[31:26].
- `funct`  in  6  IR[5:0].
- `rt`  in  5  IR[20:16]; selects REGIMM branches.
- `waitrequest`  in  1  memory bus stall.
- `muldiv_busy`  in  1  mult/div unit busy (used only with `MULDIV_STALL_EN`).
- `pc_zero`  in  1  next PC equals 0x00000000.
- `active`  out  1  core running.
- `mem_read`, `mem_write`  out  1  bus strobes.
- `iord`  out  1  bus address select: 0 = PC, 1 = ALU result.
- `ir_write`, `pc_write`  out  1  register enables.
- `regdst`  out  2  write-register select: 00 = rt, 01 = rd, 10 = r31.
- `memtoreg`  out  2  write-back source: 00 = ALU, 01 = memory, 10 = PC+4.
- `aluop`  out  `ALUOP_W`  ALU operation code (package enum).
- `alusrc`  out  1  ALU operand B: 0 = register, 1 = immediate.
- `regwrite`, `branch`, `jump`  out  1  datapath strobes.
- `muldiv_start`  out  1  one-cycle pulse that launches MULT/MULTU/DIV/DIVU.
- `illegal_instr`  out  1  one-cycle pulse on an undefined opcode.
- `bus_error`  out  1  sticky wait-timeout flag.

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, MULDIV_WAIT, HALT.
- FETCH:
  - Drives `mem_read=1`, `iord=0`.
  - Holds while `waitrequest=1`.
  - The first cycle with `waitrequest=0` pulses `ir_write` and `pc_write` (PC+4), then goes to DECODE.
- DECODE: one cycle. Classifies the instruction through the decode sub-module.
- EXEC:
  - `aluop` and `alusrc` are valid.
  - Branches (opcodes 1, 4–7) pulse `branch`.
  - J, JAL, JR and JALR pulse `jump`.
- Next state after EXEC:
  - ALU R-type and I-type (opcodes 0, 9–15): WB.
  - Loads (32–38) and stores (40, 41, 43): MEM.
  - JAL, JALR, and BLTZAL/BGEZAL (`rt[4]=1`): WB with `memtoreg=10`, `regdst=10`, or `regdst=01` for JALR.
  - J, JR and other branches: FETCH.
- Mult/div:
  - MULT, MULTU, DIV and DIVU pulse `muldiv_start` in EXEC.
  - They go to MULDIV_WAIT only when `MULDIV_STALL_EN` is defined; otherwise to FETCH.
- MEM:
  - `iord=1`; `mem_read` for loads, `mem_write` for stores.
  - Holds while `waitrequest=1`.
  - On completion, loads go to WB and stores go to FETCH.
- WB: `regwrite=1` for exactly one cycle, then FETCH.
- Halt: any transition into FETCH with `pc_zero=1` goes to HALT instead. In HALT, `active=0` and all strobes are 0. HALT is exited only by `reset`.
- Undefined opcode: pulse `illegal_instr` in DECODE, then FETCH with no writes (treated as a NOP).
- Wait counter:
  - Counts consecutive `waitrequest` cycles in FETCH or MEM; clears on every accepted access.
  - If `MEM_WAIT_MAX>0` and the count reaches `MEM_WAIT_MAX`, set `bus_error` and go to HALT. The strobes drop in the same cycle.
- LUI uses the dedicated `aluop` value LUI, not ADD.
- Loads and stores use ADD for address generation.

## Timing
- Reset values:
  - State: FETCH.
  - `active=1`; `bus_error=0`; wait count 0.
  - All strobes are forced to 0 while `reset=1`.
- The first fetch strobe appears in the cycle after `reset` deasserts.
- Cycle counts with zero wait states:
  - ALU and link instructions: 4.
  - Load: 5.
  - Store: 4.
  - Branch and jump: 3.
- Each `waitrequest` cycle adds 1 cycle.
- All outputs are Moore outputs (a function of state only), except:
  - `ir_write` and `pc_write` in FETCH, which are qualified by `!waitrequest`.
  - `illegal_instr`.
- Reset mid-access: strobes drop in the same cycle. Any pending bus transaction is abandoned.

## Configuration
- `MULDIV_STALL_EN` defined:
  - MULDIV_WAIT holds while `muldiv_busy=1` and exits to FETCH on the first cycle with `muldiv_busy=0`.
  - MFHI and MFLO issued while busy also wait in EXEC until `muldiv_busy=0`.
- `MULDIV_STALL_EN` undefined:
  - `muldiv_busy` is ignored; the mult/div unit is assumed to be single-cycle.

## Structure
- `mips_cpu_pkg` holds:
  - the opcode and funct localparams;
  - the `aluop` enum: 0 RTYPE, 1 LTZ, 2 GEZ, 3 EQ, 4 NE, 5 LEZ, 6 GTZ, 7 ADD, 8 SLT, 9 SLTU, 10 AND, 11 OR, 12 XOR, 13 LUI;
  - the `regdst` and `memtoreg` encodings;
  - the state typedef.
- Sub-module `mips_cpu_decode` (combinational) maps `opcode`, `funct` and `rt` to an instruction class plus `aluop`, `alusrc`, `regdst` and `memtoreg`.
- The FSM and the wait counter live in the top module.

## Test plan
- ADDIU, zero wait states: `ir_write` on cycle 1; `regwrite=1` and `aluop=7` on cycle 4; back in FETCH on cycle 5.
- LW with `waitrequest` high for 3 cycles in MEM: `mem_read` is held 4 cycles with `iord=1`; `regwrite` arrives with `memtoreg=01` on cycle 8.
- JAL: `jump` pulses in EXEC; WB has `regdst=10`, `memtoreg=10`. Then with `pc_zero=1`, the FSM enters HALT, `active=0`, and all strobes stay 0 for 10 or more cycles.
- `MEM_WAIT_MAX=4` with `waitrequest` stuck at 1 in FETCH: `bus_error=1` and HALT after 4 cycles; a `reset` pulse clears both.
- DIV with `MULDIV_STALL_EN` and `muldiv_busy` high for 6 cycles: `muldiv_start` is a single pulse, and FETCH resumes the cycle after busy falls. Without the macro, FETCH follows EXEC directly.
- Opcode 6'd63: `illegal_instr` pulses once; no `regwrite` or `mem_write`; next state is FETCH.
